// File: rtl/vxc_chunk_sequencer_if.sv
// Handshake/bus bundle between the chunk sequencer, the cluster memories and
// the vector-by-constant datapath. slave = sequencer side, master = environment.
interface vxc_chunk_sequencer_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int NO_OF_UNITS = 8,
  parameter int CNT_WIDTH   = 16
);
  logic                   start;
  logic                   op_in;
  logic [ADDR_WIDTH-1:0]  rd_base;
  logic [ADDR_WIDTH-1:0]  wr_base;
  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_rd_addr;
  logic                   dp_in_valid;
  logic                   dp_op;
  logic [NO_OF_UNITS-1:0] dp_lane_mask;
  logic                   dp_out_valid;
  logic                   result_mem_we;
  logic [ADDR_WIDTH-1:0]  result_wr_addr;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [CNT_WIDTH-1:0]   chunks_written;

  modport master (
    output start, op_in, rd_base, wr_base, dp_out_valid,
    input  mem_rd_en, mem_rd_addr, dp_in_valid, dp_op, dp_lane_mask,
           result_mem_we, result_wr_addr, busy, done, err, chunks_written
  );

  modport slave (
    input  start, op_in, rd_base, wr_base, dp_out_valid,
    output mem_rd_en, mem_rd_addr, dp_in_valid, dp_op, dp_lane_mask,
           result_mem_we, result_wr_addr, busy, done, err, chunks_written
  );
endinterface

// File: rtl/vxc_chunk_sequencer.sv
// Streams a vector through the vector-by-constant datapath one chunk per clk,
// tracks in-flight chunks and writes results back in arrival order.
module vxc_chunk_sequencer #(
  parameter int NUMBER_OF_EQUATIONS_PER_CLUSTER = 16,
  parameter int NO_OF_UNITS                     = 8,
  parameter int ADDR_WIDTH                      = 8,
  parameter int CNT_WIDTH                       = 16,
  parameter int TIMEOUT                         = 64
) (
  input logic                  clk,
  input logic                  reset,
  vxc_chunk_sequencer_if.slave bus
);
  localparam int NCHUNK = (NUMBER_OF_EQUATIONS_PER_CLUSTER + NO_OF_UNITS - 1) / NO_OF_UNITS;
  localparam int REM    = NUMBER_OF_EQUATIONS_PER_CLUSTER % NO_OF_UNITS;

  localparam logic [NO_OF_UNITS-1:0] FULL_MASK = '1;
  localparam logic [NO_OF_UNITS-1:0] LAST_MASK =
    (REM == 0) ? FULL_MASK : (FULL_MASK >> (NO_OF_UNITS - REM));

  localparam logic [CNT_WIDTH-1:0] NCHUNK_C = CNT_WIDTH'(NCHUNK);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NCHUNK - 1);
  // Abort fires on the (TIMEOUT-1)th quiet cycle so DONE lands exactly
  // TIMEOUT cycles after the last result.
  localparam logic [CNT_WIDTH-1:0] TO_LIMIT = CNT_WIDTH'(TIMEOUT - 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state;
  logic [CNT_WIDTH-1:0]   issue_cnt;
  logic [CNT_WIDTH-1:0]   write_cnt;
  logic [CNT_WIDTH-1:0]   outstanding;
  logic [CNT_WIDTH-1:0]   idle_cnt;
  logic [ADDR_WIDTH-1:0]  rd_base_q;
  logic [ADDR_WIDTH-1:0]  wr_base_q;
  logic                   op_q;
  logic                   err_q;
  logic                   dp_vld_q;
  logic [NO_OF_UNITS-1:0] mask_q;

  logic issuing;
  logic active;
  logic start_ok;
  logic accept;
  logic spurious;

  assign issuing  = (state == S_ISSUE);
  assign active   = (state != S_IDLE);
  assign start_ok = (state == S_IDLE) && bus.start;
  // A same-cycle dp_in_valid counts as in flight (zero-latency datapath).
  assign accept   = active && bus.dp_out_valid && ((outstanding != '0) || dp_vld_q);
  assign spurious = bus.dp_out_valid && !accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      issue_cnt   <= '0;
      write_cnt   <= '0;
      outstanding <= '0;
      idle_cnt    <= '0;
      rd_base_q   <= '0;
      wr_base_q   <= '0;
      op_q        <= 1'b0;
      err_q       <= 1'b0;
      dp_vld_q    <= 1'b0;
      mask_q      <= '0;
    end else begin
      // Read data returns one cycle after the strobe.
      dp_vld_q <= issuing;
      mask_q   <= issuing ? ((issue_cnt == LAST_IDX) ? LAST_MASK : FULL_MASK) : '0;

      if (start_ok) begin
        op_q        <= bus.op_in;
        rd_base_q   <= bus.rd_base;
        wr_base_q   <= bus.wr_base;
        err_q       <= 1'b0;
        issue_cnt   <= '0;
        write_cnt   <= '0;
        outstanding <= '0;
        idle_cnt    <= '0;
        state       <= S_ISSUE;
      end else begin
        if (spurious) err_q <= 1'b1;
        if (accept) write_cnt <= write_cnt + 1'b1;

        case ({dp_vld_q, accept})
          2'b10:   outstanding <= outstanding + 1'b1;
          2'b01:   outstanding <= outstanding - 1'b1;
          default: outstanding <= outstanding;
        endcase

        if (active) begin
          if (bus.dp_out_valid)   idle_cnt <= '0;
          else if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
        end

        case (state)
          S_ISSUE: begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == LAST_IDX) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (write_cnt == NCHUNK_C) begin
              state <= S_DONE;
            end else if (!bus.dp_out_valid && idle_cnt == TO_LIMIT) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_rd_en      = issuing;
  assign bus.mem_rd_addr    = issuing ? (rd_base_q + issue_cnt[ADDR_WIDTH-1:0]) : '0;
  assign bus.dp_in_valid    = dp_vld_q;
  assign bus.dp_lane_mask   = mask_q;
  assign bus.dp_op          = op_q;
  assign bus.result_mem_we  = accept;
  assign bus.result_wr_addr = accept ? (wr_base_q + write_cnt[ADDR_WIDTH-1:0]) : '0;
  assign bus.busy           = active;
  assign bus.done           = (state == S_DONE);
  assign bus.err            = err_q;
  assign bus.chunks_written = write_cnt;
endmodule

// File: tb/tb_vxc_chunk_sequencer.sv
// Bench for vxc_chunk_sequencer: table of jobs checked through a scoreboard,
// plus hand sequences for reset, spurious results and a 20-element vector.
module tb_vxc_chunk_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vxc_chunk_sequencer_if #(.ADDR_WIDTH(8), .NO_OF_UNITS(8), .CNT_WIDTH(16)) bus ();
  vxc_chunk_sequencer_if #(.ADDR_WIDTH(8), .NO_OF_UNITS(8), .CNT_WIDTH(16)) bus20 ();

  vxc_chunk_sequencer u_dut (.clk(clk), .reset(reset), .bus(bus));
  vxc_chunk_sequencer #(.NUMBER_OF_EQUATIONS_PER_CLUSTER(20)) u_dut20 (
    .clk(clk), .reset(reset), .bus(bus20));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Datapath models: fixed latency delay lines, optional dropped chunk.
  int         lat = 4;
  int         drop_idx = -1;
  int         in_idx = 0;
  logic [15:0] sr = '0;
  logic       dp_out_m = 1'b0;
  logic       spur_in = 1'b0;
  assign bus.dp_out_valid = dp_out_m | spur_in;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      sr = '0;
      in_idx = 0;
    end else begin
      sr = {sr[14:0], bus.dp_in_valid && (in_idx != drop_idx)};
      if (bus.dp_in_valid) in_idx++;
      if (bus.done) in_idx = 0;
    end
    dp_out_m = sr[lat];
  end

  logic [15:0] sr20 = '0;
  logic        out20 = 1'b0;
  assign bus20.dp_out_valid = out20;
  always @(posedge clk) begin
    #1;
    if (reset) sr20 = '0;
    else       sr20 = {sr20[14:0], bus20.dp_in_valid};
    out20 = sr20[2];
  end

  // Scoreboard: expectations pushed at job launch, popped as the DUT emits.
  logic [7:0] exp_rd[$];
  logic [7:0] exp_wr[$];
  logic [7:0] exp_mask[$];
  logic       exp_op = 1'b0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         last_out_cyc = 0;
  logic       prev_rd = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      exp_rd.delete();
      exp_wr.delete();
      exp_mask.delete();
      prev_rd = 1'b0;
    end else begin
      if (bus.dp_in_valid || prev_rd) chk("dp_in_valid_lag", bus.dp_in_valid, prev_rd);
      if (bus.mem_rd_en) begin
        chk("rd_expected_q", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) chk("rd_addr", bus.mem_rd_addr, exp_rd.pop_front());
      end
      if (bus.dp_in_valid) begin
        chk("mask_expected_q", exp_mask.size() != 0, 1);
        if (exp_mask.size() != 0) chk("lane_mask", bus.dp_lane_mask, exp_mask.pop_front());
        chk("dp_op", bus.dp_op, exp_op);
      end
      if (bus.result_mem_we) begin
        chk("wr_expected_q", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) chk("wr_addr", bus.result_wr_addr, exp_wr.pop_front());
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.dp_out_valid) last_out_cyc = cyc;
      prev_rd = bus.mem_rd_en;
    end
  end

  typedef struct {
    logic [7:0] rd;
    logic [7:0] wr;
    logic       op;
    int         lat;
    int         drop;
    int         restart;
    logic       exp_err;
    int         exp_chunks;
  } vec_t;

  vec_t vecs[6];

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"},   bus.mem_rd_en, 0);
    chk({tag, "_rd_addr"}, bus.mem_rd_addr, 0);
    chk({tag, "_in_vld"},  bus.dp_in_valid, 0);
    chk({tag, "_op"},      bus.dp_op, 0);
    chk({tag, "_mask"},    bus.dp_lane_mask, 0);
    chk({tag, "_we"},      bus.result_mem_we, 0);
    chk({tag, "_wr_addr"}, bus.result_wr_addr, 0);
    chk({tag, "_busy"},    bus.busy, 0);
    chk({tag, "_done"},    bus.done, 0);
    chk({tag, "_err"},     bus.err, 0);
    chk({tag, "_chunks"},  bus.chunks_written, 0);
  endtask

  task automatic pulse_start(input logic [7:0] rb, input logic [7:0] wb, input logic op);
    @(posedge clk); #1;
    bus.rd_base = rb;
    bus.wr_base = wb;
    bus.op_in   = op;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
  endtask

  task automatic run_job(input string tag, input vec_t v);
    int n;
    int d0;
    lat = v.lat;
    drop_idx = v.drop;
    exp_op = v.op;
    for (int i = 0; i < 2; i++) begin
      exp_rd.push_back(v.rd + 8'(i));
      exp_mask.push_back(8'hFF);
      if (i != v.drop) exp_wr.push_back(v.wr + 8'(i));
    end
    d0 = done_cnt;
    pulse_start(v.rd, v.wr, v.op);
    bus.rd_base = ~v.rd;
    bus.wr_base = ~v.wr;
    bus.op_in   = ~v.op;
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_err_clr"}, bus.err, 0);
    if (v.restart >= 0) begin
      repeat (v.restart) @(posedge clk);
      pulse_start(~v.rd, ~v.wr, ~v.op);
    end
    n = 0;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({tag, "_done_seen"}, n < 300, 1);
    chk({tag, "_err"}, bus.err, v.exp_err);
    chk({tag, "_chunks"}, bus.chunks_written, v.exp_chunks);
    if (v.drop >= 0) chk({tag, "_timeout_gap"}, done_cyc - last_out_cyc, 64);
    repeat (5) @(negedge clk);
    #1;
    chk({tag, "_busy_low"}, bus.busy, 0);
    chk({tag, "_one_done"}, done_cnt - d0, 1);
    chk({tag, "_sb_empty"}, exp_rd.size() + exp_wr.size() + exp_mask.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, d0, rc, ic, wc, dn;
    vecs[0] = '{8'h10, 8'h40, 1'b0, 4, -1, -1, 1'b0, 2};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 1, -1, -1, 1'b0, 2};
    vecs[2] = '{8'h20, 8'h80, 1'b0, 0, -1, -1, 1'b0, 2};
    vecs[3] = '{8'h50, 8'h60, 1'b1, 4, -1,  0, 1'b0, 2};
    vecs[4] = '{8'h70, 8'hF0, 1'b0, 6, -1,  5, 1'b0, 2};
    vecs[5] = '{8'h10, 8'h40, 1'b0, 4,  1, -1, 1'b1, 1};

    bus.start = 1'b0; bus.op_in = 1'b0; bus.rd_base = '0; bus.wr_base = '0;
    bus20.start = 1'b0; bus20.op_in = 1'b0; bus20.rd_base = '0; bus20.wr_base = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_zero("in_reset");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");

    for (int k = 0; k < 6; k++) run_job($sformatf("vec%0d", k), vecs[k]);

    // Spurious result while idle: flagged, never written.
    @(posedge clk); #1;
    spur_in = 1'b1;
    @(negedge clk);
    chk("spur_no_we", bus.result_mem_we, 0);
    @(posedge clk); #1;
    spur_in = 1'b0;
    chk("spur_err", bus.err, 1);
    run_job("after_spur", vecs[0]);

    // Reset in DRAIN with one chunk still in flight.
    lat = 4; drop_idx = -1; exp_op = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_rd.push_back(8'h10 + 8'(i));
      exp_mask.push_back(8'hFF);
      exp_wr.push_back(8'h40 + 8'(i));
    end
    pulse_start(8'h10, 8'h40, 1'b1);
    n = 0;
    while (!bus.result_mem_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_first_wr", n < 50, 1);
    reset = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    chk_zero("mid_reset");
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("rst_no_done", done_cnt - d0, 0);
    run_job("after_rst", vecs[0]);

    // 20-element vector: three chunks, last one half populated.
    @(posedge clk); #1;
    bus20.rd_base = 8'h05; bus20.wr_base = 8'h07; bus20.op_in = 1'b1; bus20.start = 1'b1;
    @(posedge clk); #1;
    bus20.start = 1'b0;
    n = 0; rc = 0; ic = 0; wc = 0; dn = 0;
    while (dn == 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus20.mem_rd_en) begin
        chk("n20_rd_addr", bus20.mem_rd_addr, 8'h05 + 8'(rc));
        rc++;
      end
      if (bus20.dp_in_valid) begin
        chk("n20_mask", bus20.dp_lane_mask, (ic == 2) ? 8'h0F : 8'hFF);
        chk("n20_op", bus20.dp_op, 1);
        ic++;
      end
      if (bus20.result_mem_we) begin
        chk("n20_wr_addr", bus20.result_wr_addr, 8'h07 + 8'(wc));
        wc++;
      end
      if (bus20.done) begin
        dn++;
        chk("n20_chunks", bus20.chunks_written, 3);
        chk("n20_err", bus20.err, 0);
      end
    end
    chk("n20_reads", rc, 3);
    chk("n20_inputs", ic, 3);
    chk("n20_writes", wc, 3);
    chk("n20_done", dn, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
